lsu: RTL and testbench
======================

# lsu

Load/store unit for the RV32I datapath, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data, and runs a single-outstanding request/response handshake with data memory. It drives byte enables and lane-replicated store data. Load data is returned sign- or zero-extended, with the destination register, to the writeback stage.

## Interface
- No parameters; data/address width fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute stage presents a memory op.
- `req_ready` out 1: LSU idle; request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- `req_addr` in 32: effective address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `mem_valid` out 1: memory request valid.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_addr` out 32: word address, bits [1:0] always 00.
- `mem_we` out 1: write strobe.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `resp_valid` out 1: one-cycle completion pulse (loads and stores).
- `resp_load` out 1: completion is a load; writeback enable.
- `resp_rd` out 5, `resp_data` out 32: load destination and extended data; 0 for stores.
- `resp_err` out 1: op completed without memory access (illegal funct3 or misaligned).

## Operation
- FSM states are IDLE, REQ, WAIT and RESP.
- IDLE: `req_ready`=1. On accept, register we/funct3/addr/wdata/rd. Go to RESP with `resp_err`=1 if the op is illegal. Otherwise go to REQ.
- Illegal ops: load funct3 ∈ {011,110,111} and store funct3 ∉ {000,001,010}.
- REQ: `mem_valid`=1 with all `mem_*` held stable until `mem_ready`. On handshake, a store goes to RESP and a load goes to WAIT.
- WAIT: on `mem_rvalid`, capture the extended data and go to RESP.
- `mem_rvalid` is ignored in every state other than WAIT.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. A new request can be accepted in the following cycle.
- Byte enables by width:
  - B: `mem_be` = 0001 << addr[1:0], `mem_wdata` = {4{wdata[7:0]}}.
  - H: `mem_be` = 0011 << {addr[1],0}, `mem_wdata` = {2{wdata[15:0]}}.
  - W: `mem_be` = 1111, `mem_wdata` = wdata.
  - Loads drive `mem_be` as for stores of the same width, with `mem_we`=0.
- Load extraction: shifted = `mem_rdata` >> (8·addr[1:0]). Then B/H sign-extend from bit 7/15, BU/HU zero-extend, W passes through.
- On an error response, `resp_data`=0 and `resp_load`=0; the register file must not be written.

## Timing
- Reset: state IDLE. `req_ready`=1 in the cycle after reset deasserts. All other outputs are 0, including `mem_*`, `resp_*` and `mem_addr`.
- Store, `mem_ready` tied 1: accept at cycle 0, `mem_valid` at cycle 1, `resp_valid` at cycle 2.
- Load, `mem_rvalid` 1 cycle after handshake: accept at 0, handshake at 1, rvalid at 2, `resp_valid` at 3.
- Memory stalls (`mem_ready`=0 or late `mem_rvalid`) extend REQ or WAIT without bound. No timeout.
- `req_ready`=0 in every state except IDLE. A request presented outside IDLE must be held by the producer.
- Reset mid-operation: return to IDLE next cycle and drop the in-flight op; no response is issued. A stale `mem_rvalid` after reset is ignored.
- `resp_*` outputs are registered; `mem_*` outputs are driven from registered state only.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H with addr[0]=1, or W with addr[1:0]≠00, skips memory and goes IDLE→RESP.
  - That response has `resp_err`=1 and `resp_data`=0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned offsets are masked: H clears addr[0], W clears addr[1:0].
  - The access then proceeds normally; `resp_err` only flags illegal funct3.

## Structure
- `lsu_pkg`:
  - FSM state enum.
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Byte-enable width constant.
- Sub-module `lsu_align` (combinational) handles be/wdata replication and load shift/extend. It is unit-testable alone.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `mem_ready`=1 → `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `resp_valid` at cycle 2 with `resp_load`=0.
- SB addr 0x103, wdata 0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LB addr 0x101 with rdata 0x0000_8000 → `resp_data`=0xFFFFFF80. The same access as LBU → 0x00000080.
- LH addr 0x202, rdata 0x8001_1234, rd=5, `mem_ready` low 3 cycles, rvalid 2 cycles later → `resp_data`=0xFFFF8001, `resp_rd`=5, single `resp_valid` pulse.
- LW addr 0x102:
  - With `LSU_MISALIGN_TRAP_EN`: no `mem_valid`, `resp_err`=1, `resp_data`=0.
  - Without it: `mem_addr`=0x100 and a normal response.
- `rst` asserted while in WAIT, then `mem_rvalid` pulses → no `resp_valid`; `req_ready`=1 in the cycle after reset deasserts. funct3=011 load → `resp_err`=1 with no memory access.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and helpers for the load/store unit
package lsu_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally allow the unsigned B/H forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    end
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request, data-memory and response signals of the load/store unit
interface lsu_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;

  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            resp_valid;
  logic            resp_load;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;

  // The LSU itself: serves execute-stage requests and drives data memory.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready,
    output mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output resp_valid, resp_load, resp_rd, resp_data, resp_err
  );

  // The surroundings: execute stage, data memory and writeback.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready,
    input  mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  resp_valid, resp_load, resp_rd, resp_data, resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/store-lane replication and load shift/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Byte enables follow the access width; store data is replicated on every lane.
  always_comb begin
    be_o    = '0;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane to bit 0, then sign- or zero-extend by funct3.
  always_comb begin
    rdata_o = shifted;
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'b0, shifted[7:0]};
      F3_HU:   rdata_o = {16'b0, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit; LSU_MISALIGN_TRAP_EN makes misaligned H/W ops error out instead of masking
module lsu
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_e      state_q, state_d;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_q;

  logic            resp_valid_q, resp_valid_d;
  logic            resp_load_q,  resp_load_d;
  logic [4:0]      resp_rd_q,    resp_rd_d;
  logic [XLEN-1:0] resp_data_q,  resp_data_d;
  logic            resp_err_q,   resp_err_d;

  logic            req_err;
  logic [XLEN-1:0] req_addr_eff;

  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

  lsu_align u_align (
    .funct3_i (f3_q),
    .offset_i (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (bus.mem_rdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  // Classify the incoming request and form the address that gets captured.
  always_comb begin
    req_err      = f3_illegal(bus.req_we, bus.req_funct3);
    req_addr_eff = bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
        (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`else
    if (bus.req_funct3[1:0] == 2'b01) begin
      req_addr_eff[0] = 1'b0;
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      req_addr_eff[1:0] = 2'b00;
    end
`endif
  end

  // Next state, memory-side outputs from registered state, and response next-values.
  always_comb begin
    state_d       = state_q;
    resp_valid_d  = 1'b0;
    resp_load_d   = 1'b0;
    resp_rd_d     = '0;
    resp_data_d   = '0;
    resp_err_d    = 1'b0;
    bus.req_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        bus.mem_we    = we_q;
        bus.mem_be    = al_be;
        bus.mem_wdata = we_q ? al_wdata : '0;
        if (bus.mem_ready) begin
          if (we_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_load_d  = 1'b1;
          resp_rd_d    = rd_q;
          resp_data_d  = al_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and registered response; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_load_q  <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_load_q  <= resp_load_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Capture the operation on acceptance; held steady until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (state_q == ST_IDLE && bus.req_valid) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= req_addr_eff;
      wdata_q <= bus.req_wdata;
      rd_q    <= bus.req_rd;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_load  = resp_load_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed table, reset corner cases and randomized ops against a reference model
module tb_lsu;
  import lsu_pkg::*;

  localparam int LIM = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();
  lsu dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic        mem;
    logic        load;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          rdy;
    int          rv;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic        rdy_acc;
    logic        got;
    logic        mem_seen;
    logic        mem_stable;
    logic        mem_extra;
    logic        after_ok;
    int          lat;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic        mwe;
    logic [31:0] mwdata;
    logic        rload;
    logic        rerr;
    logic [4:0]  rrd;
    logic [31:0] data;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour computed from access size and byte offsets.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int rdy, input int rv);
    exp_t        e;
    int          size;
    int          off;
    int          sh;
    logic [31:0] eff;
    logic [31:0] v;
    bit          illegal;
    e.err = 1'b0; e.mem = 1'b0; e.load = 1'b0; e.maddr = '0; e.be = '0;
    e.wdata = '0; e.data = '0; e.lat = 1;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    illegal = we ? (f3 > 3'd2) : (size == 0 || f3 == 3'd6);
    if (illegal) begin
      e.err = 1'b1;
      return e;
    end
    off = int'(addr[1:0]) % size;
`ifdef LSU_MISALIGN_TRAP_EN
    if (off != 0) begin
      e.err = 1'b1;
      return e;
    end
    eff = addr;
`else
    eff = addr - 32'(off);
`endif
    e.mem   = 1'b1;
    e.maddr = eff & 32'hFFFF_FFFC;
    e.be    = 4'(((1 << size) - 1) << eff[1:0]);
    for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = wdata[8*(b % size) +: 8];
    if (we) begin
      e.lat = 2 + rdy;
    end else begin
      e.load = 1'b1;
      e.lat  = 3 + rdy + rv;
      sh     = 8 * int'(eff[1:0]);
      v      = rdata >> sh;
      if (size < 4) begin
        v = v & ((32'd1 << (8 * size)) - 32'd1);
        if (!f3[2] && v[8*size-1]) v = v - (32'd1 << (8 * size));
      end
      e.data = v;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                               input int rdy, input int rv, input logic err, input logic mem,
                               input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] mwdata,
                               input logic [31:0] data, input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.rdy = rdy; v.rv = rv;
    v.e.err = err; v.e.mem = mem; v.e.load = !we && !err; v.e.maddr = maddr; v.e.be = be;
    v.e.wdata = mwdata; v.e.data = data; v.e.lat = lat;
    return v;
  endfunction

  // Present one op, act as memory with the given stall/latency, and record what the DUT did.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input int rdy, input int rv, output obs_t o);
    bit hs;
    bit got;
    int stall;
    int rv_k;
    o.rdy_acc = 1'b0; o.got = 1'b0; o.mem_seen = 1'b0; o.mem_stable = 1'b1; o.mem_extra = 1'b0;
    o.after_ok = 1'b0; o.lat = 0; o.maddr = '0; o.be = '0; o.mwe = 1'b0; o.mwdata = '0;
    o.rload = 1'b0; o.rerr = 1'b0; o.rrd = '0; o.data = '0;
    hs = 0; got = 0; stall = 0; rv_k = 0;
    @(negedge clk);
    o.rdy_acc          = bus.req_ready;
    bus.req_valid      = 1'b1;
    bus.req_we         = we;
    bus.req_funct3     = f3;
    bus.req_addr       = addr;
    bus.req_wdata      = wdata;
    bus.req_rd         = rd;
    bus.mem_ready      = 1'b0;
    bus.mem_rvalid     = 1'b0;
    for (int c = 1; c <= LIM && !got; c++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (bus.resp_valid) begin
        got     = 1;
        o.lat   = c;
        o.rload = bus.resp_load;
        o.rerr  = bus.resp_err;
        o.rrd   = bus.resp_rd;
        o.data  = bus.resp_data;
      end else if (bus.mem_valid) begin
        if (hs) o.mem_extra = 1'b1;
        if (!o.mem_seen) begin
          o.mem_seen = 1'b1;
          o.maddr    = bus.mem_addr;
          o.be       = bus.mem_be;
          o.mwe      = bus.mem_we;
          o.mwdata   = bus.mem_wdata;
        end else if (bus.mem_addr !== o.maddr || bus.mem_be !== o.be ||
                     bus.mem_we !== o.mwe || bus.mem_wdata !== o.mwdata) begin
          o.mem_stable = 1'b0;
        end
        if (stall == rdy) begin
          bus.mem_ready = 1'b1;
          hs            = 1;
        end else begin
          stall++;
          bus.mem_rvalid = 1'b1;
        end
      end else if (hs && !we) begin
        if (rv_k == rv) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
        end
        rv_k++;
      end
    end
    o.got = got;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    o.after_ok = !bus.resp_valid && bus.req_ready && !bus.mem_valid;
    if (!got) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic we, input logic [4:0] rd,
                          input obs_t o, input exp_t e);
    check({tag, ".ready"}, 32'(o.rdy_acc), 32'd1);
    check({tag, ".done"},  32'(o.got), 32'd1);
    check({tag, ".lat"},   32'(o.lat), 32'(e.lat));
    check({tag, ".err"},   32'(o.rerr), 32'(e.err));
    check({tag, ".load"},  32'(o.rload), 32'(e.load));
    check({tag, ".rd"},    32'(o.rrd), e.load ? 32'(rd) : 32'd0);
    check({tag, ".data"},  o.data, e.data);
    check({tag, ".memacc"}, 32'(o.mem_seen), 32'(e.mem));
    if (e.mem && o.mem_seen) begin
      check({tag, ".maddr"}, o.maddr, e.maddr);
      check({tag, ".be"},    32'(o.be), 32'(e.be));
      check({tag, ".mwe"},   32'(o.mwe), 32'(we));
      if (we) check({tag, ".mwdata"}, o.mwdata, e.wdata);
      check({tag, ".stable"}, 32'(o.mem_stable), 32'd1);
      check({tag, ".extra"},  32'(o.mem_extra), 32'd0);
    end
    check({tag, ".after"}, 32'(o.after_ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[$];
    obs_t  o;
    exp_t  e;
    bit    quiet;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [4:0]  r_rd;
    int          r_rdy, r_rv;

    vecs.push_back(mkv(1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 0, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 2));
    vecs.push_back(mkv(1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 32'h0, 0, 0, 0, 1, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0, 2));
    vecs.push_back(mkv(0, 3'd0, 32'h101, 32'h0, 5'd3, 32'h00008000, 0, 0, 0, 1, 32'h100, 4'h2, 32'h0, 32'hFFFFFF80, 3));
    vecs.push_back(mkv(0, 3'd4, 32'h101, 32'h0, 5'd3, 32'h00008000, 0, 0, 0, 1, 32'h100, 4'h2, 32'h0, 32'h00000080, 3));
    vecs.push_back(mkv(0, 3'd1, 32'h202, 32'h0, 5'd5, 32'h80011234, 3, 1, 0, 1, 32'h200, 4'hC, 32'h0, 32'hFFFF8001, 7));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mkv(0, 3'd2, 32'h102, 32'h0, 5'd7, 32'h12345678, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mkv(1, 3'd1, 32'h101, 32'h5678, 5'd0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
`else
    vecs.push_back(mkv(0, 3'd2, 32'h102, 32'h0, 5'd7, 32'h12345678, 0, 0, 0, 1, 32'h100, 4'hF, 32'h0, 32'h12345678, 3));
    vecs.push_back(mkv(1, 3'd1, 32'h101, 32'h5678, 5'd0, 32'h0, 0, 0, 0, 1, 32'h100, 4'h3, 32'h56785678, 32'h0, 2));
`endif
    vecs.push_back(mkv(0, 3'd3, 32'h100, 32'h0, 5'd9, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mkv(1, 3'd1, 32'h102, 32'h1234BEEF, 5'd0, 32'h0, 1, 0, 0, 1, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0, 3));
    vecs.push_back(mkv(0, 3'd5, 32'h102, 32'h0, 5'd2, 32'h80011234, 0, 2, 0, 1, 32'h100, 4'hC, 32'h0, 32'h00008001, 5));
    vecs.push_back(mkv(1, 3'd4, 32'h100, 32'h11223344, 5'd0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mkv(0, 3'd0, 32'h100, 32'h0, 5'd31, 32'hAABBCC7F, 0, 0, 0, 1, 32'h100, 4'h1, 32'h0, 32'h0000007F, 3));
    vecs.push_back(mkv(0, 3'd2, 32'h204, 32'h0, 5'd12, 32'hCAFEF00D, 2, 3, 0, 1, 32'h204, 4'hF, 32'h0, 32'hCAFEF00D, 8));

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.req_ready", 32'(bus.req_ready), 32'd1);
    check("reset.mem_ctl", {27'b0, bus.mem_valid, bus.mem_be}, 32'd0);
    check("reset.mem_addr", bus.mem_addr, 32'd0);
    check("reset.mem_wdata", {bus.mem_wdata[31:1], bus.mem_we}, 32'd0);
    check("reset.resp_ctl", {24'b0, bus.resp_valid, bus.resp_load, bus.resp_err, bus.resp_rd}, 32'd0);
    check("reset.resp_data", bus.resp_data, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].rdata,
             vecs[i].rdy, vecs[i].rv, o);
      check_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].rd, o, vecs[i].e);
    end

    // Reset while a load waits for read data; later rvalid pulses must be ignored.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h300; bus.req_rd = 5'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("midrst.mem_valid", 32'(bus.mem_valid), 32'd1);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("midrst.wait_ready", {30'b0, bus.req_ready, bus.mem_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555AAAA;
    quiet = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("midrst.req_ready", 32'(bus.req_ready), 32'd1);
      if (bus.resp_valid || bus.mem_valid) quiet = 0;
      bus.mem_rvalid = (k % 2 == 0);
    end
    bus.mem_rvalid = 1'b0;
    check("midrst.no_resp", 32'(quiet), 32'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 80; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_rd    = 5'($urandom_range(0, 31));
      r_rdy   = int'($urandom_range(0, 3));
      r_rv    = int'($urandom_range(0, 3));
      e = model(r_we, r_f3, r_addr, r_wdata, r_rdata, r_rdy, r_rv);
      run_op(r_we, r_f3, r_addr, r_wdata, r_rd, r_rdata, r_rdy, r_rv, o);
      check_op($sformatf("rnd%0d", i), r_we, r_rd, o, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
